// File: rtl/latch_stim_gen_pkg.sv
// rtl/latch_stim_gen_pkg.sv - shared FSM encodings and default timing constants for latch_stim_gen
package latch_stim_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // 100 MHz board clock: 20 ms debounce, 0.5 s enable pulse
    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEF_PULSE_CYCLES    = 50_000_000;
    localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/latch_stim_gen_debounce_cell.sv
// rtl/latch_stim_gen_debounce_cell.sv - 2-FF synchroniser plus stable-count debouncer for one raw input
//
// Ports:
//   clk  in   board clock
//   rst  in   synchronous, active-high reset
//   raw  in   asynchronous, bouncy input
//   db   out  debounced level; changes only after DEBOUNCE_CYCLES
//             consecutive cycles of the synchronised input disagreeing with it
module debounce_cell
    import latch_stim_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Any cycle of agreement restarts the count, so the counter can never
    // climb past CNT_LAST: it is cleared the moment it reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db     <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/latch_stim_gen.sv
// rtl/latch_stim_gen.sv - debounced cp/d stimulus generator for the gated D-latch exercise
//
// Ports:
//   clk      in   100 MHz board clock
//   rst      in   synchronous, active-high reset
//   btn_raw  in   raw push button
//   sw_raw   in   raw slide switch
//   mode     in   0 = fixed-width cp pulse per press, 1 = cp follows button level
//   cp_out   out  latch enable (registered)
//   d_out    out  debounced switch level (registered)
//   btn_db   out  debounced button level (registered)
//   busy     out  high while a pulse is running or awaiting button release
module latch_stim_gen
    import latch_stim_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic sw_raw,
    input  logic mode,
    output logic cp_out,
    output logic d_out,
    output logic btn_db,
    output logic busy
);

    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             cp_next;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_next;
    logic             btn_db_q;
    logic             rise;

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn_db (
        .clk(clk),
        .rst(rst),
        .raw(btn_raw),
        .db (btn_db)
    );

    // d_out is never gated by cp_out so latch transparency stays visible
    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_sw_db (
        .clk(clk),
        .rst(rst),
        .raw(sw_raw),
        .db (d_out)
    );

    assign rise = btn_db & ~btn_db_q;

    always_comb begin
        state_next = state;
        cp_next    = cp_out;
        pcnt_next  = pcnt;
        case (state)
            ST_IDLE: begin
                pcnt_next = '0;
                if (mode) begin
                    cp_next = btn_db;
                end else if (rise) begin
                    state_next = ST_PULSE;
                    cp_next    = 1'b1;
                end else begin
                    // also covers a 1->0 mode change with the button held:
                    // no pulse until a fresh rise
                    cp_next = 1'b0;
                end
            end
            ST_PULSE: begin
                // button activity is ignored; the pulse always runs full width
                cp_next = 1'b1;
                if (pcnt == PCNT_LAST) begin
                    cp_next    = 1'b0;
                    state_next = ST_HOLD;
                end else begin
                    pcnt_next = pcnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                cp_next = 1'b0;
                if (!btn_db) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cp_next    = 1'b0;
                pcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cp_out   <= 1'b0;
            busy     <= 1'b0;
            pcnt     <= '0;
            btn_db_q <= 1'b0;
        end else begin
            state    <= state_next;
            cp_out   <= cp_next;
            busy     <= (state_next != ST_IDLE);
            pcnt     <= pcnt_next;
            btn_db_q <= btn_db;
        end
    end

endmodule

// File: tb/tb_latch_stim_gen.sv
// tb/tb_latch_stim_gen.sv - self-checking bench for latch_stim_gen with a behavioural reference model
module tb_latch_stim_gen;

    localparam int DEB = 4;
    localparam int PUL = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic sw_raw;
    logic mode;
    logic cp_out;
    logic d_out;
    logic btn_db;
    logic busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    latch_stim_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES   (PUL),
        .CNT_W          (26)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .sw_raw (sw_raw),
        .mode   (mode),
        .cp_out (cp_out),
        .d_out  (d_out),
        .btn_db (btn_db),
        .busy   (busy)
    );

    // Reference model: sampled inputs move through a two-deep delay line; a
    // debounced level flips after DEB consecutive disagreeing samples; the
    // pulse is a countdown of remaining high cycles followed by a wait for release.
    bit m_bs1, m_bs2, m_ss1, m_ss2;
    bit m_btn_db, m_sw_db, m_prev_db;
    bit m_cp, m_wait_rel;
    int m_brun, m_srun, m_left;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic deb(inout bit lvl, inout int run, input bit s);
        if (s == lvl) begin
            run = 0;
        end else begin
            run++;
            if (run == DEB) begin
                lvl = s;
                run = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit old_db;
        bit was_rise;
        if (rst) begin
            {m_bs1, m_bs2, m_ss1, m_ss2} = '0;
            {m_btn_db, m_sw_db, m_prev_db, m_cp, m_wait_rel} = '0;
            m_brun = 0;
            m_srun = 0;
            m_left = 0;
        end else begin
            old_db   = m_btn_db;
            was_rise = m_btn_db && !m_prev_db;
            deb(m_btn_db, m_brun, m_bs2);
            deb(m_sw_db, m_srun, m_ss2);
            m_bs2 = m_bs1;
            m_bs1 = btn_raw;
            m_ss2 = m_ss1;
            m_ss1 = sw_raw;
            if (m_left > 0) begin
                m_left--;
                m_cp = (m_left > 0);
                if (m_left == 0) m_wait_rel = 1'b1;
            end else if (m_wait_rel) begin
                m_cp = 1'b0;
                if (!old_db) m_wait_rel = 1'b0;
            end else if (mode) begin
                m_cp = old_db;
            end else if (was_rise) begin
                m_left = PUL;
                m_cp   = 1'b1;
            end else begin
                m_cp = 1'b0;
            end
            m_prev_db = old_db;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_cp"},   cp_out, m_cp);
        check({tag, "_d"},    d_out,  m_sw_db);
        check({tag, "_bdb"},  btn_db, m_btn_db);
        check({tag, "_busy"}, busy,   (m_left > 0) || m_wait_rel);
    endtask

    initial begin
        int  hi;
        int  rises;
        bit  prev_cp;

        // 1. reset with both raw inputs high
        rst = 1'b1; btn_raw = 1'b1; sw_raw = 1'b1; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t1_rst");
            check("t1_rst_cp0", cp_out, 1'b0);
            check("t1_rst_bdb0", btn_db, 1'b0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step("t1_rel");
            if (i == 5) check("t1_bdb_before6", btn_db, 1'b0);
            if (i == 6) check("t1_bdb_at6", btn_db, 1'b1);
        end
        btn_raw = 1'b0; sw_raw = 1'b0;
        for (int i = 0; i < 12; i++) step("t1_settle");

        // 2. bounce reject on the switch
        for (int i = 0; i < 20; i++) begin
            sw_raw = ((i / 2) % 2) == 0;
            step("t2_bounce");
            check("t2_bounce_d0", d_out, 1'b0);
        end
        sw_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step("t2_hold");
            if (i == 5) check("t2_d_before6", d_out, 1'b0);
            if (i == 6) check("t2_d_at6", d_out, 1'b1);
        end

        // 3. pulse mode, long press
        mode = 1'b0; btn_raw = 1'b1;
        hi = 0; rises = 0; prev_cp = cp_out;
        for (int i = 1; i <= 45; i++) begin
            if (i == 31) btn_raw = 1'b0;
            step("t3");
            if (i == 6) check("t3_cp_low_at_db_rise", cp_out, 1'b0);
            if (i == 7) check("t3_cp_high_next", cp_out, 1'b1);
            if (cp_out) hi++;
            if (cp_out && !prev_cp) rises++;
            prev_cp = cp_out;
        end
        check("t3_width8", hi == PUL, 1'b1);
        check("t3_one_pulse", rises == 1, 1'b1);
        check("t3_idle_busy", busy, 1'b0);

        // 4. short press still yields a full pulse
        btn_raw = 1'b1;
        hi = 0; rises = 0; prev_cp = cp_out;
        for (int i = 1; i <= 30; i++) begin
            if (i == 6) btn_raw = 1'b0;
            step("t4");
            if (cp_out) hi++;
            if (cp_out && !prev_cp) rises++;
            prev_cp = cp_out;
        end
        check("t4_width8", hi == PUL, 1'b1);
        check("t4_one_pulse", rises == 1, 1'b1);
        check("t4_idle_busy", busy, 1'b0);

        // 5a. level mode follows btn_db
        mode = 1'b1; btn_raw = 1'b1;
        hi = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 13) btn_raw = 1'b0;
            step("t5a");
            if (cp_out) hi++;
        end
        check("t5a_level_len12", hi == 12, 1'b1);

        // 5b. mode flip mid-pulse has no effect on the running pulse
        mode = 1'b0; btn_raw = 1'b1;
        hi = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) mode = 1'b1;
            if (i == 11) btn_raw = 1'b0;
            step("t5b");
            if (cp_out) hi++;
        end
        check("t5b_width8", hi == PUL, 1'b1);
        mode = 1'b0;

        // 6. reset at pulse cycle 4
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) step("t6_pre");
        check("t6_in_pulse", cp_out, 1'b1);
        rst = 1'b1;
        step("t6_rst");
        check("t6_cp_dropped", cp_out, 1'b0);
        check("t6_busy_dropped", busy, 1'b0);
        rst = 1'b0;
        hi = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) btn_raw = 1'b0;
            step("t6_post");
            if (cp_out) hi++;
        end
        check("t6_no_resume", hi == 0, 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5, 0) == 0)   btn_raw = ~btn_raw;
            if ($urandom_range(4, 0) == 0)   sw_raw  = ~sw_raw;
            if ($urandom_range(24, 0) == 0)  mode    = ~mode;
            rst = ($urandom_range(149, 0) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
